tcu_fp32_narrow_pack: RTL
=========================

# tcu_fp32_narrow_pack

Output-side narrowing packer for the tensor core. It takes the FP32 dot-product results produced by the FEDP pipeline, rounds each one to FP16 or BF16 with round-to-nearest-even, and packs two narrowed results per 32-bit register word, low half first. Results travel under a valid/ready handshake and are written back as packed half-precision operands, the inverse of the unpack-and-widen path at the FEDP input.

## Interface
- `NANBOX`, default 1: when `XLEN` is 64, 1 drives `out_data[63:32]` to all ones and 0 drives it to zero. Ignored when `XLEN` is 32.
- `clk` in 1: clock.
- `reset` in 1: reset; asynchronous assertion, active-low.
- `fmt_d` in 3: target format, sampled with each input beat. 1 selects FP16, 2 selects BF16, any other value is illegal.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when high together with `in_valid`.
- `in_data` in 32: FP32 value.
- `in_last` in 1: final beat of a group; it forces an odd group to flush.
- `out_valid` out 1: packed word valid.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out `XLEN`: `{hi16, lo16}`, NaN-boxed per `NANBOX`.
- `out_fflags` out 5: {NV, DZ, OF, UF, NX}, the OR of the flags from both halves.

## Operation
- **Stage 1 (convert, registered).** Round each accepted beat to its `fmt_d` format.
- **FP16 conversion:**
  - Rebias the exponent by -112.
  - Apply RNE on the 13 dropped mantissa bits.
  - A mantissa carry increments the exponent.
  - A result exponent ≥ 31 gives ±inf (0x7C00 / 0xFC00) with OF|NX.
- **BF16 conversion:**
  - Apply RNE on the 16 dropped bits.
  - A carry into exponent 0xFF gives ±inf with OF|NX.
  - FP32 subnormal inputs pass through the same rounding.
- **NaN input:** output is the canonical NaN (FP16 0x7E00, BF16 0x7FC0). NV is set only for a signaling NaN (`in_data[22]`==0).
- **Inf and zero:** pass through with the sign kept and no flags.
- **FP16 tiny results** (rebiased exponent ≤ 0) are handled per Configuration.
- **Illegal `fmt_d`:** half = 0x0000, NV set.
- NX is set whenever any nonzero bit is dropped.
- **Stage 2 (pack):**
  - A one-bit `half_pending` flag plus a 16-bit low register and a 5-bit flag register hold the first half.
  - Second half: the output register loads `{hi, lo}` with flags OR'd, and `half_pending` clears.
  - First half with `in_last`: the output register loads `{16'h0000, lo}` directly.
- **Format mixing:** a mixed `fmt_d` within a pair is legal. Each half uses its own format.
- **Handshake:**
  - `in_ready` = !s1_valid || s1 can drain.
  - s1 drains when it becomes the pending low half, or when the output register is empty or being consumed (`out_ready`).
  - `out_data` and `out_fflags` stay stable while `out_valid` && !`out_ready`.
  - No bubbles at full throughput: one beat per cycle in, one word per two cycles out.

## Timing
- **Reset values:** while `reset` is low, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_fflags`=0, `half_pending`=0 and s1_valid=0. `in_ready` rises in the first cycle after deassertion.
- **Latency:** a packed word is visible with `out_valid` in the second cycle after the edge that accepted its final beat (2-cycle latency).
- **Reset mid-group:** a pending low half and any in-flight beat are discarded. No partial word is emitted.
- **Simultaneous events:** the output register can be consumed and reloaded on the same edge. While `out_valid` && !`out_ready`, at most one more beat sits in s1 plus one pending half, after which `in_ready` deasserts.
- **`in_last` on the second half:** normal pair; no extra word is produced.

## Configuration
- `TCU_PACK_SUBNORM_EN`
  - **Defined:** tiny FP16 results are denormalized, with RNE applied on the shifted mantissa. UF is set only when the tiny result is inexact, together with NX. Rounding up to 0x0400 yields the normal minimum, and UF is still set if inexact.
  - **Undefined:** tiny FP16 results flush to ±0 with UF|NX, unless the input is an exact zero. BF16 is unaffected in both modes.

## Test plan
- **FP16 pair:** FP16, `in_data` 0x3F800000 then 0x40000000 with `in_last` on the second beat -> `out_data` 0x40003C00, fflags 0x00.
- **BF16 ties:** BF16, 0x3F808000 then 0x3F818000 -> 0x3F823F80, fflags 0x01 (NX).
- **FP16 overflow and sNaN:**
  - FP16, 0x47800000 then 0x3F800000 -> 0x3C007C00, fflags 0x05 (OF|NX).
  - sNaN 0x7F800001 -> half 0x7E00, NV.
- **Odd group:** FP16, single beat 0x3F800000 with `in_last` -> 0x00003C00. With `XLEN`=64 and `NANBOX`=1 -> 0xFFFFFFFF00003C00.
- **Backpressure:** stream 8 beats with `out_ready` held low for 5 cycles mid-stream -> `in_ready` drops, the 4 words arrive in order, there is no loss or duplication, and `out_data` is stable while stalled.
- **Subnormal:** FP16, 0x33800000 (2^-24) -> with the macro, half 0x0001 and flags 0. Without it, 0x0000 with flags 0x03. Then assert reset with a half pending -> no word is emitted.

Source files
------------

// File: rtl/tcu_fp32_narrow_pack.sv
// FP32 -> FP16/BF16 RNE narrowing packer, two halves per word, low first.
// Optional macro TCU_PACK_SUBNORM_EN keeps tiny FP16 results as subnormals.
module tcu_fp32_narrow_pack #(
    parameter int XLEN   = 32,
    parameter int NANBOX = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      fmt_d,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_fflags
);

    // Returns {fflags, half}.
    function automatic logic [20:0] narrow(
        input logic [31:0] x,
        input logic [2:0]  fmt
    );
        logic              s;
        logic [7:0]        e;
        logic [22:0]       m;
        logic signed [9:0] ue;
        logic              g;
        logic              st;
        logic              ru;
        logic [19:0]       nsum;
        logic [14:0]       bsum;
        logic [15:0]       h;
        logic [4:0]        f;
`ifdef TCU_PACK_SUBNORM_EN
        logic [5:0]        sh;
        logic [41:0]       wide;
        logic [10:0]       kr;
`endif
        s    = x[31];
        e    = x[30:23];
        m    = x[22:0];
        ue   = $signed({2'b00, e}) - 10'sd112;
        g    = 1'b0;
        st   = 1'b0;
        ru   = 1'b0;
        nsum = '0;
        bsum = '0;
        h    = '0;
        f    = '0;
`ifdef TCU_PACK_SUBNORM_EN
        sh   = '0;
        wide = '0;
        kr   = '0;
`endif
        if (fmt != 3'd1 && fmt != 3'd2) begin
            f = 5'b10000;
        end else if (e == 8'hFF && m != '0) begin
            h = (fmt == 3'd1) ? 16'h7E00 : 16'h7FC0;
            f = {!m[22], 4'b0000};
        end else if (e == 8'hFF) begin
            h = (fmt == 3'd1) ? {s, 15'h7C00} : {s, 15'h7F80};
        end else if (e == 8'h00 && m == '0) begin
            h = {s, 15'h0000};
        end else if (fmt == 3'd2) begin
            g    = x[15];
            st   = |x[14:0];
            ru   = g & (st | x[16]);
            bsum = x[30:16] + {14'b0, ru};
            h    = {s, bsum};
            f    = {2'b00, bsum[14:7] == 8'hFF, 1'b0, g | st};
        end else if (ue > 0) begin
            g    = m[12];
            st   = |m[11:0];
            ru   = g & (st | m[13]);
            nsum = {ue, m[22:13]} + {19'b0, ru};
            if (nsum[19:10] >= 10'd31) begin
                h = {s, 15'h7C00};
                f = 5'b00101;
            end else begin
                h = {s, nsum[14:0]};
                f = {4'b0000, g | st};
            end
        end else begin
`ifdef TCU_PACK_SUBNORM_EN
            // Shift is at least 14; distances past 32 only feed sticky.
            sh   = (e < 8'd94) ? 6'd32 : 6'(8'd126 - e);
            wide = {e != 8'd0, m, 18'b0} >> (sh - 6'd14);
            g    = wide[31];
            st   = |wide[30:0];
            ru   = g & (st | wide[32]);
            kr   = {1'b0, wide[41:32]} + {10'b0, ru};
            h    = {s, 4'b0000, kr};
            f    = {3'b000, g | st, g | st};
`else
            h = {s, 15'h0000};
            f = 5'b00011;
`endif
        end
        return {f, h};
    endfunction

    function automatic logic [XLEN-1:0] boxed(input logic [31:0] w);
        logic [XLEN-1:0] r;
        r       = {XLEN{(NANBOX != 0) && (XLEN > 32)}};
        r[31:0] = w;
        return r;
    endfunction

    logic        run;
    logic        s1_valid;
    logic [15:0] s1_half;
    logic [4:0]  s1_flags;
    logic        s1_last;
    logic        half_pending;
    logic [15:0] lo_q;
    logic [4:0]  lo_f;
    logic        out_free;
    logic        s1_drain;
    logic        load_out;
    logic        in_fire;

    always_comb begin
        out_free = !out_valid || out_ready;
        s1_drain = s1_valid &&
                   ((!half_pending && !s1_last) || out_free);
        load_out = s1_drain && (half_pending || s1_last);
        in_ready = run && (!s1_valid || s1_drain);
        in_fire  = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run      <= 1'b0;
            s1_valid <= 1'b0;
            s1_half  <= '0;
            s1_flags <= '0;
            s1_last  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (in_fire) begin
                s1_valid            <= 1'b1;
                {s1_flags, s1_half} <= narrow(in_data, fmt_d);
                s1_last             <= in_last;
            end else if (s1_drain) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_pending <= 1'b0;
            lo_q         <= '0;
            lo_f         <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_fflags   <= '0;
        end else begin
            if (s1_drain) begin
                if (half_pending) begin
                    out_data     <= boxed({s1_half, lo_q});
                    out_fflags   <= s1_flags | lo_f;
                    half_pending <= 1'b0;
                end else if (s1_last) begin
                    out_data   <= boxed({16'h0000, s1_half});
                    out_fflags <= s1_flags;
                end else begin
                    half_pending <= 1'b1;
                    lo_q         <= s1_half;
                    lo_f         <= s1_flags;
                end
            end
            if (load_out) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
